// File: rtl/emap_gather_scheduler.sv
// Row sequencer for the 8-wide column-gather unit: issues one chunk read per credit,
// then tracks the fixed-latency gather pipeline so valid/last/row-id line up with output_row.
module emap_gather_scheduler #(
    parameter int MULT_W     = 32,
    parameter int CHUNK_W    = 8,
    parameter int ROWID_W    = 16,
    parameter int GATHER_LAT = 2,
    parameter int CREDITS    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               row_valid,
    output logic               row_ready,
    input  logic [MULT_W-1:0]  row_multiples,
    input  logic [ROWID_W-1:0] row_id,
    output logic [CHUNK_W-1:0] chunk_sel,
    output logic               read_strobe,
    output logic               out_valid,
    output logic               out_last,
    output logic [ROWID_W-1:0] out_row_id,
    input  logic               credit_return,
    output logic               busy,
    output logic               err_zero_len,
    output logic               err_credit_ovf
);

    localparam int CRED_W = $clog2(CREDITS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [MULT_W-1:0]  MAX_CHUNKS    = MULT_W'((2 ** CHUNK_W) - 1);
    localparam logic [CHUNK_W-1:0] MAX_CHUNK_SEL = CHUNK_W'((2 ** CHUNK_W) - 1);
    localparam logic [CRED_W-1:0]  CRED_FULL     = CRED_W'(CREDITS);
    localparam logic [CRED_W-1:0]  CRED_ONE      = CRED_W'(1);

    logic [1:0]         state_reg;
    logic [CHUNK_W-1:0] count_reg;
    logic [CHUNK_W-1:0] chunk_idx_reg;
    logic [ROWID_W-1:0] row_id_reg;
    logic [CHUNK_W-1:0] chunk_sel_reg;
    logic               read_strobe_reg;
    logic               strobe_last_reg;
    logic [ROWID_W-1:0] strobe_id_reg;
    logic [CRED_W-1:0]  credits_reg;
    logic [CRED_W-1:0]  credits_next;
    logic               err_zero_len_reg;
    logic               err_credit_ovf_reg;

    logic               pipe_valid_reg [GATHER_LAT];
    logic               pipe_last_reg  [GATHER_LAT];
    logic [ROWID_W-1:0] pipe_id_reg    [GATHER_LAT];

    logic               issue_fire;
    logic               return_ok;
    logic               is_last;
    logic               upstream_busy;
    logic               any_stage;
    logic [CHUNK_W-1:0] row_count_clamped;

    always_comb begin
        issue_fire = (state_reg == ST_ISSUE) && (credits_reg != '0);
        // A return while already full cannot correspond to a real slot, so it is dropped.
        return_ok  = credit_return && (credits_reg != CRED_FULL);
        credits_next = credits_reg;
        if (issue_fire) begin
            credits_next = credits_next - CRED_ONE;
        end
        if (return_ok) begin
            credits_next = credits_next + CRED_ONE;
        end
        is_last = (chunk_idx_reg == (count_reg - CHUNK_W'(1)));
        row_count_clamped = (row_multiples > MAX_CHUNKS) ? MAX_CHUNK_SEL
                                                         : row_multiples[CHUNK_W-1:0];
    end

    // The final stage may still be presenting data when IDLE is re-entered; only the
    // strobe register and the earlier stages hold back the return to IDLE.
    always_comb begin
        upstream_busy = read_strobe_reg;
        for (int i = 0; i < GATHER_LAT - 1; i++) begin
            upstream_busy = upstream_busy | pipe_valid_reg[i];
        end
        any_stage = 1'b0;
        for (int i = 0; i < GATHER_LAT; i++) begin
            any_stage = any_stage | pipe_valid_reg[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= ST_IDLE;
            count_reg          <= '0;
            chunk_idx_reg      <= '0;
            row_id_reg         <= '0;
            chunk_sel_reg      <= '0;
            read_strobe_reg    <= 1'b0;
            strobe_last_reg    <= 1'b0;
            strobe_id_reg      <= '0;
            credits_reg        <= CRED_FULL;
            err_zero_len_reg   <= 1'b0;
            err_credit_ovf_reg <= 1'b0;
        end else begin
            err_zero_len_reg <= 1'b0;
            read_strobe_reg  <= 1'b0;
            strobe_last_reg  <= 1'b0;
            credits_reg      <= credits_next;
            if (credit_return && (credits_reg == CRED_FULL)) begin
                err_credit_ovf_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (row_valid) begin
                        if (row_multiples == '0) begin
                            err_zero_len_reg <= 1'b1;
                        end else begin
                            count_reg     <= row_count_clamped;
                            row_id_reg    <= row_id;
                            chunk_idx_reg <= '0;
                            state_reg     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // While starved the select already shows the next chunk to be issued.
                    chunk_sel_reg <= chunk_idx_reg;
                    if (issue_fire) begin
                        read_strobe_reg <= 1'b1;
                        strobe_last_reg <= is_last;
                        strobe_id_reg   <= row_id_reg;
                        chunk_idx_reg   <= chunk_idx_reg + CHUNK_W'(1);
                        if (is_last) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!upstream_busy) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < GATHER_LAT; gi++) begin : g_stage
            logic               valid_in;
            logic               last_in;
            logic [ROWID_W-1:0] id_in;

            if (gi == 0) begin : g_head
                assign valid_in = read_strobe_reg;
                assign last_in  = read_strobe_reg & strobe_last_reg;
                assign id_in    = strobe_id_reg;
            end else begin : g_body
                assign valid_in = pipe_valid_reg[gi-1];
                assign last_in  = pipe_last_reg[gi-1];
                assign id_in    = pipe_id_reg[gi-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_valid_reg[gi] <= 1'b0;
                    pipe_last_reg[gi]  <= 1'b0;
                    pipe_id_reg[gi]    <= '0;
                end else begin
                    pipe_valid_reg[gi] <= valid_in;
                    pipe_last_reg[gi]  <= last_in;
                    pipe_id_reg[gi]    <= id_in;
                end
            end
        end
    endgenerate

    assign row_ready      = (state_reg == ST_IDLE);
    assign chunk_sel      = chunk_sel_reg;
    assign read_strobe    = read_strobe_reg;
    assign out_valid      = pipe_valid_reg[GATHER_LAT-1];
    assign out_last       = pipe_last_reg[GATHER_LAT-1];
    assign out_row_id     = pipe_id_reg[GATHER_LAT-1];
    assign busy           = (state_reg != ST_IDLE) || read_strobe_reg || any_stage;
    assign err_zero_len   = err_zero_len_reg;
    assign err_credit_ovf = err_credit_ovf_reg;

endmodule
